viterbi_acs_array: RTL and testbench

- Parametrised add-compare-select array for a rate-1/2 Viterbi decoder with constraint length K and 2^(K-1) trellis states.
- Each accepted step takes four branch metrics, updates all registered state metrics and emits one survivor decision bit per state to the traceback memory.
- Also emits the index of the best (minimum-metric) state so traceback can start there.
- Offers frame-start initialisation and two metric normalisation modes: MSB-clear threshold or modulo comparison.

---
 rtl/viterbi_acs_array.sv | 133 +++++++++++++
 tb/tb_viterbi_acs_array.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_array.sv
// viterbi_acs_array
// Add-compare-select array for a rate-1/2 Viterbi decoder with constraint
// length K and N = 2^(K-1) trellis states. Each accepted step adds the four
// branch metrics to the stored path metrics. It keeps the survivor into every
// next state and registers the new metrics. It also reports one decision bit
// per state and the index of the best (minimum) metric.
//
// Ports
//   clk            clock
//   rst            asynchronous active-low reset
//   in_valid       branch metrics valid; one trellis step per cycle when high
//   start          qualified by in_valid; metrics restart from {0, INIT_BIAS..}
//   branch_metric  four unsigned metrics indexed by code bits {c0,c1}
//   out_valid      registered in_valid; decision/best_state/state_metric valid
//   decision       survivor bit per next state (1 = predecessor with lsb 1)
//   best_state     index of the minimum new metric, ties to the lowest index
//   state_metric   registered path metrics
//
// Handshake: there is no backpressure. Every cycle with in_valid=1 is one
// trellis step, back-to-back steps are allowed. The results appear on the
// following cycle with out_valid=1. On cycles without in_valid, out_valid
// drops to 0 and all other outputs hold.
module viterbi_acs_array #(
   parameter int K         = 3,
   parameter int G0        = 7,
   parameter int G1        = 5,
   parameter int BM_W      = 4,
   parameter int SM_W      = 7,
   parameter int NORM_MODE = 0,
   parameter int INIT_BIAS = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic                            start,
   input  logic [3:0][BM_W-1:0]            branch_metric,
   output logic                            out_valid,
   output logic [(1<<(K-1))-1:0]           decision,
   output logic [K-2:0]                    best_state,
   output logic [(1<<(K-1))-1:0][SM_W-1:0] state_metric
);

   localparam int N = 1 << (K - 1);
   localparam logic [K-1:0]    G0_V   = K'(G0);
   localparam logic [K-1:0]    G1_V   = K'(G1);
   localparam logic [SM_W-1:0] BIAS_V = SM_W'(INIT_BIAS);

   // Metric ordering. NORM_MODE=1 lets metrics wrap, so "a before b" is
   // judged by the sign of the modular difference instead of magnitude.
   function automatic logic precedes(input logic [SM_W-1:0] a,
                                     input logic [SM_W-1:0] b);
      logic [SM_W-1:0] diff;
      diff = a - b;
      if (NORM_MODE == 0) return (a < b);
      else                return diff[SM_W-1];
   endfunction

   // Predecessor of next state ns whose oldest bit is b.
   function automatic logic [K-2:0] pred(input logic [K-2:0] ns, input logic b);
      return {ns[K-3:0], b};
   endfunction

   // The encoder register for the transition pred(ns,b) -> ns is exactly
   // {ns, b}: the new input bit is ns's MSB and the shifted-out bit is b.
   function automatic logic [1:0] branch_idx(input logic [K-2:0] ns, input logic b);
      logic [K-1:0] r;
      r = {ns, b};
      return {^(r & G0_V), ^(r & G1_V)};
   endfunction

   logic [N-1:0][SM_W-1:0] acs_in;
   logic [N-1:0][SM_W-1:0] new_metric;
   logic [N-1:0]           new_decision;
   logic [K-2:0]           new_best;
   logic [SM_W-1:0]        cand0;
   logic [SM_W-1:0]        cand1;
   logic                   all_msb;

   always_comb begin
      acs_in       = state_metric;
      new_metric   = '0;
      new_decision = '0;
      new_best     = '0;
      cand0        = '0;
      cand1        = '0;
      all_msb      = 1'b1;

      // Frame start replaces the stored metrics for this very step.
      if (start) begin
         acs_in[0] = '0;
         for (int s = 1; s < N; s++) acs_in[s] = BIAS_V;
      end

      for (int i = 0; i < N; i++) begin
         cand0 = acs_in[pred((K-1)'(i), 1'b0)]
               + SM_W'(branch_metric[branch_idx((K-1)'(i), 1'b0)]);
         cand1 = acs_in[pred((K-1)'(i), 1'b1)]
               + SM_W'(branch_metric[branch_idx((K-1)'(i), 1'b1)]);
         // Ties keep the even predecessor.
         new_decision[i] = precedes(cand1, cand0);
         new_metric[i]   = new_decision[i] ? cand1 : cand0;
         all_msb         = all_msb & new_metric[i][SM_W-1];
      end

      // Threshold normalisation: subtracting 2^(SM_W-1) from every state
      // preserves all differences and keeps the metrics from overflowing.
      if (NORM_MODE == 0 && all_msb) begin
         for (int i = 0; i < N; i++) new_metric[i][SM_W-1] = 1'b0;
      end

      // Strict compare keeps the lowest index on ties.
      for (int i = 1; i < N; i++) begin
         if (precedes(new_metric[i], new_metric[new_best])) new_best = (K-1)'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid    <= 1'b0;
         decision     <= '0;
         best_state   <= '0;
         state_metric <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            decision     <= new_decision;
            best_state   <= new_best;
            state_metric <= new_metric;
         end
      end
   end

endmodule

// File: tb/tb_viterbi_acs_array.sv
// tb_viterbi_acs_array
// Drives three ACS arrays from one shared stimulus stream:
//   u0: K=3, G=7/5, threshold normalisation
//   u1: K=3, G=7/5, modulo comparison
//   u2: K=7, G=171/133 octal, threshold normalisation
// A trellis model enumerates every (state, input bit) transition of the
// encoder and follows each instance. Its results are compared with all DUT
// outputs on every falling edge. Directed checks with hand-derived values
// pin the model. A K=7 traceback run shows that error-free metrics decode
// back to the transmitted bits.
`timescale 1ns/1ps
module tb_viterbi_acs_array;

   localparam int INIT_BIAS = 32;

   // ---------------- clock / reset ----------------
   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic in_valid = 1'b0;
   logic start    = 1'b0;
   logic [3:0][3:0] bm = '0;

   always #5 clk = ~clk;

   logic            ov0, ov1, ov2;
   logic [3:0]      dec0, dec1;
   logic [1:0]      best0, best1;
   logic [3:0][6:0] sm0, sm1;
   logic [63:0]     dec2;
   logic [5:0]      best2;
   logic [63:0][9:0] sm2;

   viterbi_acs_array #(.K(3), .G0(7), .G1(5), .BM_W(4), .SM_W(7), .NORM_MODE(0),
                       .INIT_BIAS(INIT_BIAS)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .start(start), .branch_metric(bm),
      .out_valid(ov0), .decision(dec0), .best_state(best0), .state_metric(sm0));

   viterbi_acs_array #(.K(3), .G0(7), .G1(5), .BM_W(4), .SM_W(7), .NORM_MODE(1),
                       .INIT_BIAS(INIT_BIAS)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .start(start), .branch_metric(bm),
      .out_valid(ov1), .decision(dec1), .best_state(best1), .state_metric(sm1));

   viterbi_acs_array #(.K(7), .G0('h79), .G1('h5B), .BM_W(4), .SM_W(10), .NORM_MODE(0),
                       .INIT_BIAS(INIT_BIAS)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .start(start), .branch_metric(bm),
      .out_valid(ov2), .decision(dec2), .best_state(best2), .state_metric(sm2));

   // ---------------- model ----------------
   int pk[3]    = '{3, 3, 7};
   int pg0[3]   = '{7, 7, 'h79};
   int pg1[3]   = '{5, 5, 'h5B};
   int pw[3]    = '{7, 7, 10};
   int pmode[3] = '{0, 1, 0};

   int mm[3][64];
   bit md[3][64];
   int mb[3];
   bit mov[3];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic int par(input int x);
      return $countones(x) & 1;
   endfunction

   task automatic model_step(input int inst);
      int  n, mask, half, ns, r, code, best, rel, best_rel;
      int  base[64];
      int  cand[64][2];
      int  nm[64];
      bit  take, all_msb;
      n    = 1 << (pk[inst] - 1);
      mask = (1 << pw[inst]) - 1;
      half = 1 << (pw[inst] - 1);
      for (int s = 0; s < n; s++) base[s] = start ? ((s == 0) ? 0 : INIT_BIAS) : mm[inst][s];
      // Forward enumeration of every encoder transition.
      for (int s = 0; s < n; s++) begin
         for (int u = 0; u < 2; u++) begin
            r    = (u << (pk[inst] - 1)) | s;
            code = 2 * par(r & pg0[inst]) + par(r & pg1[inst]);
            ns   = r >> 1;
            cand[ns][s & 1] = (base[s] + int'(bm[code])) & mask;
         end
      end
      all_msb = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (pmode[inst] == 0) take = (cand[i][1] < cand[i][0]);
         else                  take = (((cand[i][1] - cand[i][0]) & mask) >= half);
         md[inst][i] = take;
         nm[i] = take ? cand[i][1] : cand[i][0];
         if (nm[i] < half) all_msb = 1'b0;
      end
      if (pmode[inst] == 0 && all_msb) begin
         for (int i = 0; i < n; i++) nm[i] = nm[i] - half;
      end
      best = 0;
      if (pmode[inst] == 0) begin
         for (int i = 1; i < n; i++) if (nm[i] < nm[best]) best = i;
      end else begin
         // Signed distance from state 0; metrics stay within half the range.
         best_rel = 0;
         for (int i = 1; i < n; i++) begin
            rel = ((nm[i] - nm[0] + half) & mask) - half;
            if (rel < best_rel) begin
               best_rel = rel;
               best     = i;
            end
         end
      end
      for (int i = 0; i < n; i++) mm[inst][i] = nm[i];
      mb[inst] = best;
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         for (int inst = 0; inst < 3; inst++) begin
            for (int i = 0; i < 64; i++) begin
               mm[inst][i] = 0;
               md[inst][i] = 1'b0;
            end
            mb[inst]  = 0;
            mov[inst] = 1'b0;
         end
      end else begin
         for (int inst = 0; inst < 3; inst++) begin
            mov[inst] = in_valid;
            if (in_valid) model_step(inst);
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input int inst, input int idx,
                        input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s u%0d[%0d]: got %0d expected %0d", name, inst, idx, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_dec(input int inst);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 64; i++) v[i] = md[inst][i];
      return v;
   endfunction

   task automatic compare_all();
      check("out_valid", 0, 0, 64'(ov0), 64'(mov[0]));
      check("decision",  0, 0, 64'(dec0), exp_dec(0));
      check("best",      0, 0, 64'(best0), 64'(mb[0]));
      for (int i = 0; i < 4; i++) check("metric", 0, i, 64'(sm0[i]), 64'(mm[0][i]));
      check("out_valid", 1, 0, 64'(ov1), 64'(mov[1]));
      check("decision",  1, 0, 64'(dec1), exp_dec(1));
      check("best",      1, 0, 64'(best1), 64'(mb[1]));
      for (int i = 0; i < 4; i++) check("metric", 1, i, 64'(sm1[i]), 64'(mm[1][i]));
      check("out_valid", 2, 0, 64'(ov2), 64'(mov[2]));
      check("decision",  2, 0, dec2, exp_dec(2));
      check("best",      2, 0, 64'(best2), 64'(mb[2]));
      for (int i = 0; i < 64; i++) check("metric", 2, i, 64'(sm2[i]), 64'(mm[2][i]));
   endtask

   initial forever begin
      @(negedge clk);
      compare_all();
   end

   // Decisions of the K=7 array, one entry per accepted step.
   logic [63:0] dec_q[$];
   initial forever begin
      @(negedge clk);
      if (ov2 === 1'b1) dec_q.push_back(dec2);
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit st, input int b0, input int b1, input int b2, input int b3);
      @(negedge clk);
      in_valid = 1'b1;
      start    = st;
      bm[0]    = 4'(b0);
      bm[1]    = 4'(b1);
      bm[2]    = 4'(b2);
      bm[3]    = 4'(b3);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic check_sm0(input string name, input int a, input int b, input int c, input int d);
      int e[4];
      e = '{a, b, c, d};
      for (int i = 0; i < 4; i++) check(name, 0, i, 64'(sm0[i]), 64'(e[i]));
   endtask

   task automatic check_sm1_all(input string name, input int v);
      for (int i = 0; i < 4; i++) check(name, 1, i, 64'(sm1[i]), 64'(v));
   endtask

   // ---------------- stimulus ----------------
   logic [0:0] exp_q[$];
   int es, u, r, code, st_tb, errors, d;
   int h[4];

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check("reset_ov", 0, 0, 64'(ov0), 64'(0));
      check_sm0("reset_sm", 0, 0, 0, 0);

      // Frame start with bm={0,1,1,2}
      step(1'b1, 0, 1, 1, 2);
      idle();
      check("start_ov", 0, 0, 64'(ov0), 64'(1));
      check_sm0("start_sm", 0, 33, 2, 33);
      check("start_dec", 0, 0, 64'(dec0), 64'(0));
      check("start_best", 0, 0, 64'(best0), 64'(0));

      // Asynchronous reset in the middle of a burst
      step(1'b0, 1, 2, 0, 1);
      step(1'b0, 2, 0, 1, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_ov", 0, 0, 64'(ov0), 64'(0));
      check("async_rst_dec", 0, 0, 64'(dec0), 64'(0));
      check("async_rst_best", 2, 0, 64'(best2), 64'(0));
      check_sm0("async_rst_sm", 0, 0, 0, 0);
      check("async_rst_sm", 2, 5, 64'(sm2[5]), 64'(0));
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;

      // From zero metrics, no start: states 0 and 2 see bm[3]=0 on one branch
      step(1'b0, 3, 3, 3, 0);
      idle();
      check_sm0("p1_sm", 0, 3, 0, 3);
      check("p1_dec", 0, 0, 64'(dec0), 64'(4'b0001));
      check("p1_best", 0, 0, 64'(best0), 64'(0));
      check("p1_dec", 1, 0, 64'(dec1), 64'(4'b0001));

      // All-15 metrics: threshold clears at 75, modulo wraps at 150
      do_reset();
      repeat (4) step(1'b0, 15, 15, 15, 15);
      idle();
      check_sm0("thr_sm4", 60, 60, 60, 60);
      step(1'b0, 15, 15, 15, 15);
      idle();
      check_sm0("thr_sm5", 11, 11, 11, 11);
      check("thr_dec", 0, 0, 64'(dec0), 64'(0));
      check_sm1_all("mod_sm5", 75);
      repeat (5) step(1'b0, 15, 15, 15, 15);
      idle();
      check_sm1_all("mod_sm10", 22);
      check("mod_best", 1, 0, 64'(best1), 64'(0));
      idle();
      check_sm1_all("mod_hold", 22);

      // K=7 random bits, error-free Hamming metrics, random gaps
      dec_q.delete();
      exp_q.delete();
      es = 0;
      for (int t = 0; t < 1000; t++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idle();
         u    = int'($urandom_range(0, 1));
         r    = (u << 6) | es;
         code = 2 * par(r & 'h79) + par(r & 'h5B);
         es   = r >> 1;
         for (int i = 0; i < 4; i++) h[i] = $countones(i ^ code);
         exp_q.push_back(1'(u));
         step(t == 0, h[0], h[1], h[2], h[3]);
      end
      idle();
      idle();
      check("tb_steps", 2, 0, 64'(dec_q.size()), 64'(1000));
      check("tb_best", 2, 0, 64'(best2), 64'(es));
      errors = 0;
      st_tb  = int'(best2);
      if (dec_q.size() == 1000) begin
         for (int t = 999; t >= 0; t--) begin
            d = int'(dec_q[t][st_tb]);
            if (1'((st_tb >> 5) & 1) != exp_q[t]) errors++;
            st_tb = ((st_tb << 1) | d) & 63;
         end
      end else begin
         errors = 1000;
      end
      check("traceback_errors", 2, 0, 64'(errors), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
